// File: rtl/riscv_pkg.sv
// riscv_pkg
//  Shared types and constants for the RV32I write-back stage.
//  wb_sel_t : write-back source select (2'b11 is treated as ALU by users)
//  F3_*     : load funct3 encodings consumed by extensor_carga
package riscv_pkg;

   localparam int XLEN_DEF = 32;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10
   } wb_sel_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/etapa_writeback_extensor_carga.sv
// extensor_carga
//  Combinational load extractor: picks the byte/half addressed by lsb out of
//  the raw memory word and sign- or zero-extends it to 32 bits.
//  Ports:
//   rdata  in  32  raw aligned word from data memory
//   funct3 in  3   load size/sign
//   lsb    in  2   low address bits (effective address [1:0])
//   ext    out 32  extended load value
//  Halfword loads use lsb[1] only; a misaligned half is not trapped.
//  Unknown funct3 values return the full word.
module extensor_carga
   import riscv_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  lsb,
   output logic [31:0] ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (lsb)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
   end

   assign half_sel = lsb[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      ext = rdata;
      case (funct3)
         F3_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU:  ext = {24'd0, byte_sel};
         F3_LH:   ext = {{16{half_sel[15]}}, half_sel};
         F3_LHU:  ext = {16'd0, half_sel};
         default: ext = rdata;
      endcase
   end

endmodule

// File: rtl/etapa_writeback.sv
// etapa_writeback
//  MEM/WB pipeline register and write-back datapath of the RV32I core.
//  Latches the retiring instruction, extends load data, selects the
//  write-back source and drives the register file write port.
//  Optional feature macro: RETIRE_COUNT_EN (adds retired_count output).
//  Ports:
//   clk, rsta       clock, async active-high reset
//   stall, flush    hold stage / inject bubble (flush wins)
//   in_*            instruction fields from the MEM stage
//   write_reg       destination register (0 when no write)
//   write_data      write-back value
//   RegWrite        register file write enable
//   wb_valid        stage holds a real instruction
//   retired_count   retired instruction count (RETIRE_COUNT_EN only)
//  Outputs are combinational from the stage registers only.
module etapa_writeback
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
`ifdef RETIRE_COUNT_EN
   , parameter int CNT_WIDTH = 64
`endif
)(
   input  logic            clk,
   input  logic            rsta,
   input  logic            stall,
   input  logic            flush,
   input  logic            in_valid,
   input  logic [XLEN-1:0] in_alu_result,
   input  logic [XLEN-1:0] in_mem_rdata,
   input  logic [XLEN-1:0] in_pc_plus4,
   input  logic [4:0]      in_rd,
   input  logic            in_reg_write,
   input  logic [1:0]      in_wb_sel,
   input  logic [2:0]      in_funct3,
   output logic [4:0]      write_reg,
   output logic [XLEN-1:0] write_data,
   output logic            RegWrite,
   output logic            wb_valid
`ifdef RETIRE_COUNT_EN
   , output logic [CNT_WIDTH-1:0] retired_count
`endif
);

   logic            valid_q;
   logic [XLEN-1:0] alu_q;
   logic [XLEN-1:0] rdata_q;
   logic [XLEN-1:0] pc4_q;
   logic [4:0]      rd_q;
   logic            reg_write_q;
   logic [1:0]      wb_sel_q;
   logic [2:0]      funct3_q;
   logic [XLEN-1:0] load_ext;
   logic            write_en;

   always_ff @(posedge clk or posedge rsta) begin
      if (rsta) begin
         valid_q     <= 1'b0;
         alu_q       <= '0;
         rdata_q     <= '0;
         pc4_q       <= '0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
         wb_sel_q    <= '0;
         funct3_q    <= '0;
      end else if (flush) begin
         // Bubble: only validity matters, payload is left as is.
         valid_q <= 1'b0;
      end else if (!stall) begin
         valid_q     <= in_valid;
         alu_q       <= in_alu_result;
         rdata_q     <= in_mem_rdata;
         pc4_q       <= in_pc_plus4;
         rd_q        <= in_rd;
         reg_write_q <= in_reg_write;
         wb_sel_q    <= in_wb_sel;
         funct3_q    <= in_funct3;
      end
   end

   extensor_carga u_extensor (
      .rdata  (rdata_q),
      .funct3 (funct3_q),
      .lsb    (alu_q[1:0]),
      .ext    (load_ext)
   );

   // x0 is hardwired to zero, so a write to it is suppressed here.
   assign write_en  = valid_q & reg_write_q & (rd_q != 5'd0);
   assign RegWrite  = write_en;
   assign write_reg = write_en ? rd_q : 5'd0;
   assign wb_valid  = valid_q;

   always_comb begin
      write_data = alu_q;
      case (wb_sel_q)
         WB_MEM:  write_data = load_ext;
         WB_PC4:  write_data = pc4_q;
         default: write_data = alu_q;
      endcase
   end

`ifdef RETIRE_COUNT_EN
   // An instruction retires when it leaves the stage: either the stage
   // advances or a flush replaces it. Stalled cycles never count.
   logic retire;
   assign retire = valid_q & (~stall | flush);

   always_ff @(posedge clk or posedge rsta) begin
      if (rsta)
         retired_count <= '0;
      else if (retire)
         retired_count <= retired_count + CNT_WIDTH'(1);
   end
`endif

endmodule
